// File: rtl/nonce_result_fifo.sv
// Arbitrates solution nonces from the hash macros into a small FIFO read byte-wise by the register bank.
// Optional NONCE_DUP_FILTER_EN: drop a pulse repeating the last nonce seen from the same macro.
module nonce_result_fifo #(
  parameter int NUM_MACROS = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 3
) (
  input  logic                     iCLK,
  input  logic                     RST,
  input  logic [NUM_MACROS-1:0]    solution_valid,
  input  logic [NUM_MACROS*32-1:0] solution_nonce,
  input  logic [2:0]               byte_sel,
  input  logic                     read_strobe,
  input  logic                     pop_strobe,
  input  logic                     clear_overflow,
  output logic [7:0]               data_out,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [NUM_MACROS-1:0]    overflow,
  output logic                     interrupt_out
);

  localparam int MW = (NUM_MACROS > 1) ? $clog2(NUM_MACROS) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_MACROS-1:0] pending;
  logic [NUM_MACROS-1:0] vld_eff;
  logic [NUM_MACROS-1:0] grant;
  logic [NUM_MACROS-1:0] cap;
  logic [NUM_MACROS-1:0] ovf_evt;
  logic [31:0]           hold [NUM_MACROS];
  logic [39:0]           mem  [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [MW-1:0]         rr_ptr;
  logic [MW-1:0]         rr_next;
  logic [MW-1:0]         win_idx;
  logic                  win_vld;
  logic                  push;
  logic                  pop;
  logic [39:0]           head;
  logic [7:0]            rd_byte;

`ifdef NONCE_DUP_FILTER_EN
  logic [31:0]           last_nonce [NUM_MACROS];
  logic [NUM_MACROS-1:0] last_vld;
  logic [NUM_MACROS-1:0] dup;

  always_comb begin
    dup = '0;
    for (int i = 0; i < NUM_MACROS; i++)
      dup[i] = last_vld[i] && (solution_nonce[32*i +: 32] == last_nonce[i]);
  end

  assign vld_eff = solution_valid & ~dup;

  always_ff @(posedge iCLK) begin
    if (RST) begin
      last_vld <= '0;
      for (int i = 0; i < NUM_MACROS; i++) last_nonce[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MACROS; i++) begin
        if (vld_eff[i]) begin
          last_nonce[i] <= solution_nonce[32*i +: 32];
          last_vld[i]   <= 1'b1;
        end
      end
    end
  end
`else
  assign vld_eff = solution_valid;
`endif

  // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin : arb
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NUM_MACROS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_MACROS;
      if (pending[idx]) begin
        win_vld = 1'b1;
        win_idx = MW'(idx);
      end
    end
  end

  assign push    = win_vld && (count != CNT_W'(DEPTH));
  assign pop     = pop_strobe && (count != '0);
  assign grant   = push ? (NUM_MACROS'(1) << win_idx) : '0;
  // A macro being drained this cycle may capture again without overflowing.
  assign cap     = vld_eff & (~pending | grant);
  assign ovf_evt = vld_eff & pending & ~grant;
  assign rr_next = (win_idx == MW'(NUM_MACROS - 1)) ? '0 : win_idx + MW'(1);

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign head       = mem[rd_ptr];

  always_comb begin
    rd_byte = 8'h00;
    case (byte_sel)
      3'd0:    rd_byte = head[7:0];
      3'd1:    rd_byte = head[15:8];
      3'd2:    rd_byte = head[23:16];
      3'd3:    rd_byte = head[31:24];
      3'd4:    rd_byte = head[39:32];
      3'd5:    rd_byte = 8'(count);
      3'd6:    rd_byte = 8'(overflow);
      default: rd_byte = 8'h00;
    endcase
    if (fifo_empty && (byte_sel < 3'd5)) rd_byte = 8'h00;
  end

  always_ff @(posedge iCLK) begin
    if (RST) begin
      pending       <= '0;
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rr_ptr        <= '0;
      overflow      <= '0;
      data_out      <= 8'h00;
      interrupt_out <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | cap;
      for (int i = 0; i < NUM_MACROS; i++)
        if (cap[i]) hold[i] <= solution_nonce[32*i +: 32];
      if (push) begin
        mem[wr_ptr] <= {8'(win_idx), hold[win_idx]};
        wr_ptr      <= wr_ptr + PW'(1);
        rr_ptr      <= rr_next;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count         <= count_next;
      overflow      <= (clear_overflow ? '0 : overflow) | ovf_evt;
      if (read_strobe) data_out <= rd_byte;
      interrupt_out <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_nonce_result_fifo.sv
// Directed bench for nonce_result_fifo: capture latency, arbitration order, full/overflow, collisions, reset.
module tb_nonce_result_fifo;

  logic         iCLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   solution_valid = '0;
  logic [127:0] solution_nonce = '0;
  logic [2:0]   byte_sel = '0;
  logic         read_strobe = 1'b0;
  logic         pop_strobe = 1'b0;
  logic         clear_overflow = 1'b0;
  logic [7:0]   data_out;
  logic         fifo_empty;
  logic         fifo_full;
  logic [3:0]   overflow;
  logic         interrupt_out;

  int n_vec = 0;
  int n_err = 0;

  nonce_result_fifo #(.NUM_MACROS(4), .DEPTH(4), .CNT_W(3)) dut (
    .iCLK(iCLK), .RST(RST),
    .solution_valid(solution_valid), .solution_nonce(solution_nonce),
    .byte_sel(byte_sel), .read_strobe(read_strobe), .pop_strobe(pop_strobe),
    .clear_overflow(clear_overflow), .data_out(data_out),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .interrupt_out(interrupt_out)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    solution_valid = '0;
    read_strobe    = 1'b0;
    pop_strobe     = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic rd(input logic [2:0] b, input logic do_pop);
    byte_sel    = b;
    read_strobe = 1'b1;
    pop_strobe  = do_pop;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b [5];
    logic [7:0] exp_idx [4];
    logic [7:0] exp_d [4];
    logic [7:0] exp_head [6];

    // Reset state
    tick(); tick();
    RST = 1'b0;
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_irq", 32'(interrupt_out), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);

    // Single report from macro 2
    solution_valid = 4'b0100;
    solution_nonce[64 +: 32] = 32'hDEADBEEF;
    tick();
    idle();
    check("s1_pend_empty", 32'(fifo_empty), 32'd1);
    check("s1_pend_irq", 32'(interrupt_out), 32'd0);
    tick();
    check("s1_empty", 32'(fifo_empty), 32'd0);
    check("s1_irq", 32'(interrupt_out), 32'd1);
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h02};
    for (int b = 0; b < 5; b++) begin
      rd(3'(b), 1'b0);
      check($sformatf("s1_byte%0d", b), 32'(data_out), 32'(exp_b[b]));
    end
    rd(3'd5, 1'b0);
    check("s1_count", 32'(data_out), 32'd1);
    pop_strobe = 1'b1;
    tick();
    idle();
    check("s1_pop_empty", 32'(fifo_empty), 32'd1);
    check("s1_pop_irq", 32'(interrupt_out), 32'd0);
    rd(3'd0, 1'b0);
    check("s1_empty_byte0", 32'(data_out), 32'd0);
    rd(3'd7, 1'b0);
    check("s1_byte7", 32'(data_out), 32'd0);

    // Simultaneous reports from all macros, rr_ptr at 0
    do_reset();
    solution_valid = 4'b1111;
    solution_nonce = {32'h44, 32'h33, 32'h22, 32'h11};
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    check("s2_full", 32'(fifo_full), 32'd1);
    rd(3'd5, 1'b0);
    check("s2_count", 32'(data_out), 32'd4);
    rd(3'd4, 1'b0);
    check("s2_head_idx", 32'(data_out), 32'd0);

    // Full FIFO: first pulse waits pending, second overflows
    solution_valid = 4'b0010;
    solution_nonce[32 +: 32] = 32'hAAAA0001;
    tick();
    idle();
    tick();
    solution_valid = 4'b0010;
    solution_nonce[32 +: 32] = 32'hBBBB0002;
    tick();
    idle();
    check("s3_ovf", 32'(overflow), 32'h2);
    check("s3_still_full", 32'(fifo_full), 32'd1);
    rd(3'd6, 1'b0);
    check("s3_ovf_byte", 32'(data_out), 32'h02);
    pop_strobe = 1'b1;
    tick();
    idle();
    tick();
    check("s3_refull", 32'(fifo_full), 32'd1);
    rd(3'd5, 1'b0);
    check("s3_count", 32'(data_out), 32'd4);
    clear_overflow = 1'b1;
    tick();
    idle();
    check("s3_ovf_clr", 32'(overflow), 32'd0);
    exp_idx = '{8'd1, 8'd2, 8'd3, 8'd1};
    exp_d   = '{8'h22, 8'h33, 8'h44, 8'h01};
    for (int k = 0; k < 4; k++) begin
      rd(3'd4, 1'b0);
      check($sformatf("s3_idx%0d", k), 32'(data_out), 32'(exp_idx[k]));
      rd(3'd0, 1'b1);
      check($sformatf("s3_dat%0d", k), 32'(data_out), 32'(exp_d[k]));
    end
    check("s3_drained", 32'(fifo_empty), 32'd1);
    check("s3_irq", 32'(interrupt_out), 32'd0);

    // Push/pop collisions at count 2, pointers wrap
    do_reset();
    solution_valid = 4'b0011;
    solution_nonce = {32'h0, 32'h0, 32'h20, 32'h10};
    tick();
    idle();
    tick(); tick();
    exp_head = '{8'h10, 8'h20, 8'h51, 8'h52, 8'h53, 8'h54};
    for (int k = 1; k <= 7; k++) begin
      if (k <= 6) begin
        solution_valid[(k + 1) % 4] = 1'b1;
        solution_nonce[32*((k + 1) % 4) +: 32] = 32'h50 + 32'(k);
      end
      if (k >= 2) begin
        pop_strobe  = 1'b1;
        read_strobe = 1'b1;
        byte_sel    = 3'd0;
      end
      tick();
      idle();
      if (k >= 2) begin
        check($sformatf("s4_head%0d", k), 32'(data_out), 32'(exp_head[k-2]));
        check($sformatf("s4_nfull%0d", k), 32'(fifo_full), 32'd0);
      end
    end
    rd(3'd5, 1'b0);
    check("s4_count", 32'(data_out), 32'd2);
    rd(3'd4, 1'b0);
    check("s4_idx_a", 32'(data_out), 32'd2);
    rd(3'd0, 1'b1);
    check("s4_dat_a", 32'(data_out), 32'h55);
    rd(3'd0, 1'b0);
    check("s4_dat_b", 32'(data_out), 32'h56);
    rd(3'd4, 1'b0);
    check("s4_idx_b", 32'(data_out), 32'd3);

    // Reset with 3 queued and 1 pending
    solution_valid = 4'b0111;
    solution_nonce = {32'h0, 32'h73, 32'h72, 32'h71};
    tick();
    idle();
    tick(); tick();
    check("s5_pre_empty", 32'(fifo_empty), 32'd0);
    do_reset();
    check("s5_empty", 32'(fifo_empty), 32'd1);
    check("s5_ovf", 32'(overflow), 32'd0);
    check("s5_dout", 32'(data_out), 32'd0);
    check("s5_irq", 32'(interrupt_out), 32'd0);
    tick(); tick(); tick();
    check("s5_no_stale", 32'(fifo_empty), 32'd1);
    check("s5_no_stale_irq", 32'(interrupt_out), 32'd0);
    rd(3'd5, 1'b0);
    check("s5_count", 32'(data_out), 32'd0);

`ifdef NONCE_DUP_FILTER_EN
    do_reset();
    solution_nonce = '0;
    solution_nonce[31:0] = 32'h5;
    solution_valid = 4'b0001;
    tick(); idle(); tick();
    solution_valid = 4'b0001;
    tick(); idle(); tick(); tick();
    rd(3'd5, 1'b0);
    check("dup_count1", 32'(data_out), 32'd1);
    solution_nonce[31:0] = 32'h6;
    solution_valid = 4'b0001;
    tick(); idle(); tick();
    solution_nonce[31:0] = 32'h5;
    solution_valid = 4'b0001;
    tick(); idle(); tick(); tick();
    rd(3'd5, 1'b0);
    check("dup_count3", 32'(data_out), 32'd3);
    check("dup_ovf", 32'(overflow), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
